pool_column_serializer: RTL and testbench

Downstream neighbour of the max-pooling stage. Captures each pooled column (WINDOWS parallel words, one-cycle valid pulse, no backpressure upstream) into a small column FIFO, then streams the elements out one word per transfer over a valid/ready interface, tagging row/column position and end-of-frame. It decouples the bursty, non-stallable pooling output from a serial consumer such as the next conv stage's line loader or the FC input.

---
 rtl/cnn_pkg.sv | 14 +
 rtl/pool_column_serializer_if.sv | 31 +++
 rtl/column_fifo.sv | 58 +++++
 rtl/pool_column_serializer.sv | 88 ++++++++
 tb/tb_pool_column_serializer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: pixel word width/type and the serializer's
// stream state encoding.
package cnn_pkg;

   localparam int PIXEL_W = 16;

   typedef logic [PIXEL_W-1:0] pixel_t;

   typedef enum logic {
      ST_EMPTY,
      ST_STREAM
   } ser_state_t;

endpackage

// File: rtl/pool_column_serializer_if.sv
// Column input (pulse, no backpressure) plus serial valid/ready element output
// with position tags and FIFO status.
interface pool_column_serializer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int WINDOWS    = 12,
   parameter int NUM_COLS   = 12,
   parameter int FIFO_DEPTH = 2
);

   logic                            valid_in;
   logic [DATA_WIDTH-1:0]           column_in [WINDOWS-1:0];
   logic [DATA_WIDTH-1:0]           out_data;
   logic                            out_valid;
   logic                            out_ready;
   logic [$clog2(WINDOWS)-1:0]      out_row;
   logic [$clog2(NUM_COLS)-1:0]     out_col;
   logic                            out_last;
   logic                            overflow;
   logic [$clog2(FIFO_DEPTH):0]     fifo_count;

   modport master (
      output valid_in, column_in, out_ready,
      input  out_data, out_valid, out_row, out_col, out_last, overflow, fifo_count
   );

   modport slave (
      input  valid_in, column_in, out_ready,
      output out_data, out_valid, out_row, out_col, out_last, overflow, fifo_count
   );

endinterface

// File: rtl/column_fifo.sv
// Column-wide FIFO: FIFO_DEPTH entries of WINDOWS words, drop-on-full with a
// sticky overflow flag; a pop in the same cycle frees the slot for a write.
module column_fifo
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = PIXEL_W,
   parameter int WINDOWS    = 12,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_en,
   input  logic [DATA_WIDTH-1:0]         wr_data [WINDOWS-1:0],
   input  logic                          pop,
   output logic [DATA_WIDTH-1:0]         head    [WINDOWS-1:0],
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          wr_accept,
   output logic                          overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH-1:0][WINDOWS-1:0];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  full;
   logic                  pop_ok;

   assign full      = (count == CNT_W'(FIFO_DEPTH));
   assign pop_ok    = pop & (count != '0);
   assign wr_accept = wr_en & (~full | pop_ok);
   assign head      = mem[rd_ptr];

   // Payload storage carries no reset; pointers alone define what is live.
   always_ff @(posedge clk) begin
      if (wr_accept) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_accept) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)    rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_accept, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (wr_en && !wr_accept) overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/pool_column_serializer.sv
// Buffers pooled columns and streams them one element per transfer with
// row/column tags and an end-of-frame marker.
module pool_column_serializer
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = PIXEL_W,
   parameter int WINDOWS    = 12,
   parameter int NUM_COLS   = 12,
   parameter int FIFO_DEPTH = 2
) (
   input logic clk,
   input logic rst_n,
   pool_column_serializer_if.slave bus
);

   localparam int ROW_W = $clog2(WINDOWS);
   localparam int COL_W = $clog2(NUM_COLS);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [DATA_WIDTH-1:0] head [WINDOWS-1:0];
   logic [CNT_W-1:0]      count;
   logic                  wr_acc;
   logic                  overflow_q;
   logic [ROW_W-1:0]      elem_idx;
   logic [COL_W-1:0]      col_idx;
   ser_state_t            state;
   ser_state_t            state_nxt;
   logic                  xfer;
   logic                  last_elem;
   logic                  final_pop;

   column_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .WINDOWS    (WINDOWS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (bus.valid_in),
      .wr_data   (bus.column_in),
      .pop       (final_pop),
      .head      (head),
      .count     (count),
      .wr_accept (wr_acc),
      .overflow  (overflow_q)
   );

   // STREAM mirrors count != 0; it only drops when the last held column leaves
   // without a replacement arriving in the same cycle.
   always_comb begin
      state_nxt = state;
      xfer      = (state == ST_STREAM) & bus.out_ready;
      last_elem = (elem_idx == ROW_W'(WINDOWS - 1));
      final_pop = xfer & last_elem;
      case (state)
         ST_EMPTY:  if (wr_acc) state_nxt = ST_STREAM;
         ST_STREAM: if (final_pop && !wr_acc && count == CNT_W'(1)) state_nxt = ST_EMPTY;
         default:   state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_EMPTY;
         elem_idx <= '0;
         col_idx  <= '0;
      end else begin
         state <= state_nxt;
         if (xfer) begin
            if (last_elem) begin
               elem_idx <= '0;
               col_idx  <= (col_idx == COL_W'(NUM_COLS - 1)) ? '0 : col_idx + COL_W'(1);
            end else begin
               elem_idx <= elem_idx + ROW_W'(1);
            end
         end
      end
   end

   assign bus.out_valid  = (state == ST_STREAM);
   assign bus.out_data   = bus.out_valid ? head[elem_idx] : '0;
   assign bus.out_row    = elem_idx;
   assign bus.out_col    = col_idx;
   assign bus.out_last   = bus.out_valid & last_elem & (col_idx == COL_W'(NUM_COLS - 1));
   assign bus.overflow   = overflow_q;
   assign bus.fifo_count = count;

endmodule

// File: tb/tb_pool_column_serializer.sv
// Directed plus randomized stimulus for pool_column_serializer against a
// queue-of-columns reference model.
module tb_pool_column_serializer;

   localparam int DW = 16;
   localparam int W  = 12;
   localparam int NC = 12;
   localparam int D  = 2;

   typedef logic [DW-1:0] col_t [W-1:0];

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pool_column_serializer_if #(
      .DATA_WIDTH (DW), .WINDOWS (W), .NUM_COLS (NC), .FIFO_DEPTH (D)
   ) bus ();

   pool_column_serializer #(
      .DATA_WIDTH (DW), .WINDOWS (W), .NUM_COLS (NC), .FIFO_DEPTH (D)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model: queued columns, position of the head element, sticky drop flag.
   col_t mq [$];
   int   m_e   = 0;
   int   m_c   = 0;
   bit   m_ovf = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic col_t rand_col();
      col_t r;
      for (int i = 0; i < W; i++) r[i] = DW'($urandom);
      return r;
   endfunction

   function automatic col_t seq_col();
      col_t r;
      for (int i = 0; i < W; i++) r[i] = DW'(i + 1);
      return r;
   endfunction

   task automatic cycle(input bit v, input col_t col, input bit rdy);
      bit   has, xf, pop, acc;
      col_t hd;
      bus.valid_in  = v;
      bus.column_in = col;
      bus.out_ready = rdy;
      has = (mq.size() != 0);
      chk("out_valid", 32'(bus.out_valid), 32'(has));
      chk("fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      if (has) begin
         hd = mq[0];
         chk("out_data", 32'(bus.out_data), 32'(hd[m_e]));
         chk("out_row", 32'(bus.out_row), 32'(m_e));
         chk("out_col", 32'(bus.out_col), 32'(m_c));
         chk("out_last", 32'(bus.out_last), 32'((m_e == W - 1) && (m_c == NC - 1)));
      end else begin
         chk("out_last_idle", 32'(bus.out_last), 32'(0));
      end
      @(posedge clk);
      xf  = has && rdy;
      pop = xf && (m_e == W - 1);
      acc = v && ((mq.size() < D) || pop);
      if (v && !acc) m_ovf = 1'b1;
      if (pop) begin
         mq.delete(0);
         m_e = 0;
         m_c = (m_c + 1) % NC;
      end else if (xf) begin
         m_e++;
      end
      if (acc) mq.push_back(col);
      #1;
   endtask

   task automatic idle(input bit rdy);
      cycle(1'b0, rand_col(), rdy);
   endtask

   task automatic do_reset(input bit v);
      rst_n         = 1'b0;
      bus.valid_in  = v;
      bus.column_in = rand_col();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      mq.delete();
      m_e   = 0;
      m_c   = 0;
      m_ovf = 1'b0;
      chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
      chk("rst_out_data", 32'(bus.out_data), 32'(0));
      chk("rst_out_row", 32'(bus.out_row), 32'(0));
      chk("rst_out_col", 32'(bus.out_col), 32'(0));
      chk("rst_out_last", 32'(bus.out_last), 32'(0));
      chk("rst_overflow", 32'(bus.overflow), 32'(0));
      chk("rst_fifo_count", 32'(bus.fifo_count), 32'(0));
      rst_n = 1'b1;
   endtask

   initial begin
      bit prev_v;
      bit v;
      bus.valid_in  = 1'b0;
      bus.column_in = rand_col();
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      do_reset(1'b0);

      // single column 0x0001..0x000C
      cycle(1'b1, seq_col(), 1'b1);
      repeat (13) idle(1'b1);

      // full frame, then first column of the next frame
      for (int c = 0; c < NC; c++) begin
         cycle(1'b1, rand_col(), 1'b1);
         repeat (W - 1) idle(1'b1);
      end
      cycle(1'b1, rand_col(), 1'b1);
      repeat (13) idle(1'b1);

      // backpressure mid-column
      cycle(1'b1, rand_col(), 1'b1);
      repeat (4) idle(1'b1);
      repeat (5) idle(1'b0);
      repeat (10) idle(1'b1);

      // overflow: three columns while stalled
      repeat (3) begin
         cycle(1'b1, rand_col(), 1'b0);
         idle(1'b0);
      end
      repeat (3) idle(1'b0);
      chk("ovf_sticky", 32'(bus.overflow), 32'(1));
      repeat (30) idle(1'b1);

      // write coinciding with final pop while full
      do_reset(1'b1);
      cycle(1'b1, rand_col(), 1'b0);
      idle(1'b0);
      cycle(1'b1, rand_col(), 1'b0);
      idle(1'b0);
      repeat (W - 1) idle(1'b1);
      cycle(1'b1, rand_col(), 1'b1);
      chk("simul_count", 32'(bus.fifo_count), 32'(2));
      chk("simul_ovf", 32'(bus.overflow), 32'(0));
      repeat (30) idle(1'b1);

      // reset mid-stream with two columns held
      cycle(1'b1, rand_col(), 1'b0);
      idle(1'b0);
      cycle(1'b1, rand_col(), 1'b0);
      repeat (3) idle(1'b1);
      do_reset(1'b1);
      cycle(1'b1, seq_col(), 1'b1);
      repeat (13) idle(1'b1);

      // randomized traffic, at most one column every two cycles
      prev_v = 1'b0;
      for (int i = 0; i < 600; i++) begin
         v = !prev_v && ($urandom_range(0, 2) == 0);
         cycle(v, rand_col(), $urandom_range(0, 3) != 0);
         prev_v = v;
      end
      repeat (40) idle(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
